// File: rtl/debounce_multi.sv
// Multi-channel push-button conditioner: two-flop synchroniser, stability
// qualification, clean level plus registered press/release/long-press pulses.
module debounce_multi #(
    parameter int CHANNELS      = 4,
    parameter int STABLE_CYCLES = 4,
    parameter int LONG_CYCLES   = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] button_in,
    output logic [CHANNELS-1:0] button_debounce,
    output logic [CHANNELS-1:0] press_pulse,
    output logic [CHANNELS-1:0] release_pulse,
    output logic [CHANNELS-1:0] long_pulse
);

    localparam int CW_RAW = $clog2(STABLE_CYCLES + 1);
    localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic          s1;
        logic          s2;
        logic          level;
        logic          press_r;
        logic          release_r;
        logic [CW-1:0] cnt;

        // Synchroniser and stability qualification; any agreeing sample restarts the count.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1        <= 1'b0;
                s2        <= 1'b0;
                level     <= 1'b0;
                cnt       <= '0;
                press_r   <= 1'b0;
                release_r <= 1'b0;
            end else begin
                s1        <= button_in[g];
                s2        <= s1;
                press_r   <= 1'b0;
                release_r <= 1'b0;
                if (s2 == level) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    level     <= s2;
                    cnt       <= '0;
                    press_r   <= s2;
                    release_r <= ~s2;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

        assign button_debounce[g] = level;
        assign press_pulse[g]     = press_r;
        assign release_pulse[g]   = release_r;

        if (LONG_CYCLES > 0) begin : g_long
            localparam int HW = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES + 1) : 1;
            localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
            localparam logic [HW-1:0] HOLD_SAT  = HW'(LONG_CYCLES);

            logic [HW-1:0] hcnt;
            logic          long_r;

            // Hold counter parks at HOLD_SAT so a single hold yields one pulse.
            function automatic logic [HW-1:0] hold_inc(input logic [HW-1:0] h);
                return (h == HOLD_SAT) ? h : h + 1'b1;
            endfunction

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hcnt   <= '0;
                    long_r <= 1'b0;
                end else begin
                    long_r <= 1'b0;
                    if (!level) begin
                        hcnt <= '0;
                    end else if (hcnt == HOLD_LAST) begin
                        hcnt   <= HOLD_SAT;
                        long_r <= 1'b1;
                    end else begin
                        hcnt <= hold_inc(hcnt);
                    end
                end
            end

            assign long_pulse[g] = long_r;
        end else begin : g_nolong
            assign long_pulse[g] = 1'b0;
        end
    end

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi: dut_l has long-press enabled (16),
// dut_n has it disabled; both share the same inputs.
module tb_debounce_multi;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] button_in;
    logic [3:0] deb_l, prs_l, rel_l, lng_l;
    logic [3:0] deb_n, prs_n, rel_n, lng_n;

    int checks   = 0;
    int failures = 0;
    int cnt_a;
    int first_a;

    always #5 clk = ~clk;

    debounce_multi #(.CHANNELS(4), .STABLE_CYCLES(4), .LONG_CYCLES(16)) dut_l (
        .clk(clk), .rst_n(rst_n), .button_in(button_in),
        .button_debounce(deb_l), .press_pulse(prs_l),
        .release_pulse(rel_l), .long_pulse(lng_l)
    );

    debounce_multi #(.CHANNELS(4), .STABLE_CYCLES(4), .LONG_CYCLES(0)) dut_n (
        .clk(clk), .rst_n(rst_n), .button_in(button_in),
        .button_debounce(deb_n), .press_pulse(prs_n),
        .release_pulse(rel_n), .long_pulse(lng_n)
    );

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        button_in = 4'hF;
        tick(2);
        chk("rst_deb", deb_l, 4'h0);
        chk("rst_press", prs_l, 4'h0);
        chk("rst_rel", rel_l, 4'h0);
        chk("rst_long", lng_l, 4'h0);

        // Buttons held through reset release re-qualify as a fresh press.
        rst_n = 1'b1;
        tick(5);
        chk("hold_deb_e5", deb_l, 4'h0);
        chk("hold_press_e5", prs_l, 4'h0);
        tick(1);
        chk("hold_deb_e6", deb_l, 4'hF);
        chk("hold_press_e6", prs_l, 4'hF);
        chk("hold_press_n_e6", prs_n, 4'hF);
        tick(1);
        chk("hold_press_e7", prs_l, 4'h0);
        button_in = 4'h0;
        tick(5);
        chk("allrel_deb_e5", deb_l, 4'hF);
        chk("allrel_rel_e5", rel_l, 4'h0);
        tick(1);
        chk("allrel_deb_e6", deb_l, 4'h0);
        chk("allrel_rel_e6", rel_l, 4'hF);
        tick(1);
        chk("allrel_rel_e7", rel_l, 4'h0);
        tick(3);

        // Clean press/release on ch0.
        button_in = 4'h1;
        tick(5);
        chk("c0_deb_e5", deb_l, 4'h0);
        tick(1);
        chk("c0_deb_e6", deb_l, 4'h1);
        chk("c0_press_e6", prs_l, 4'h1);
        tick(1);
        chk("c0_press_e7", prs_l, 4'h0);
        tick(3);
        button_in = 4'h0;
        tick(5);
        chk("c0_deb_r5", deb_l, 4'h1);
        chk("c0_rel_r5", rel_l, 4'h0);
        tick(1);
        chk("c0_deb_r6", deb_l, 4'h0);
        chk("c0_rel_r6", rel_l, 4'h1);
        chk("c0_long", lng_l, 4'h0);
        tick(1);
        chk("c0_rel_r7", rel_l, 4'h0);
        tick(3);

        // Bounce on ch1: only the final run of four ones qualifies (edge 11).
        cnt_a   = 0;
        first_a = 0;
        for (int k = 1; k <= 14; k++) begin
            case (k)
                2, 5:    button_in = 4'h0;
                default: button_in = 4'h2;
            endcase
            tick(1);
            if (prs_l[1]) begin
                cnt_a++;
                if (first_a == 0) first_a = k;
            end
        end
        chk("bounce_npress", cnt_a, 1);
        chk("bounce_edge", first_a, 11);
        chk("bounce_deb", deb_l, 4'h2);
        button_in = 4'h0;
        tick(8);
        chk("bounce_rel_deb", deb_l, 4'h0);

        // Long press on ch2: one pulse 16 cycles after the press pulse.
        button_in = 4'h4;
        tick(6);
        chk("lp_press", prs_l, 4'h4);
        tick(15);
        chk("lp_long_15", lng_l, 4'h0);
        tick(1);
        chk("lp_long_16", lng_l, 4'h4);
        chk("lp_long_n", lng_n, 4'h0);
        tick(1);
        chk("lp_long_17", lng_l, 4'h0);
        cnt_a = 0;
        for (int k = 0; k < 100; k++) begin
            tick(1);
            if (lng_l != 4'h0) cnt_a++;
        end
        chk("lp_no_second", cnt_a, 0);
        chk("lp_deb_held", deb_l, 4'h4);
        button_in = 4'h0;
        tick(8);
        chk("lp_rel_deb", deb_l, 4'h0);

        // Short hold on ch2 (level high for 10 cycles): no long pulse.
        button_in = 4'h4;
        tick(6);
        chk("sh_press", prs_l, 4'h4);
        cnt_a = 0;
        for (int k = 0; k < 30; k++) begin
            if (k == 4) button_in = 4'h0;
            tick(1);
            if (lng_l != 4'h0) cnt_a++;
        end
        chk("sh_no_long", cnt_a, 0);
        chk("sh_deb", deb_l, 4'h0);

        // ch0 press and ch3 release land on the same edge.
        button_in = 4'h8;
        tick(8);
        chk("sim_pre_deb", deb_l, 4'h8);
        button_in = 4'h1;
        tick(5);
        chk("sim_deb_e5", deb_l, 4'h8);
        tick(1);
        chk("sim_press", prs_l, 4'h1);
        chk("sim_rel", rel_l, 4'h8);
        chk("sim_deb", deb_l, 4'h1);
        chk("sim_rel_n", rel_n, 4'h8);
        tick(1);
        chk("sim_pulses_off", {prs_l, rel_l}, 8'h00);
        button_in = 4'h0;
        tick(8);

        // Reset mid-qualification clears everything without a clock edge.
        button_in = 4'h4;
        tick(8);
        chk("mr_pre_deb", deb_l, 4'h4);
        button_in = 4'h5;
        tick(4);
        rst_n = 1'b0;
        #2;
        chk("mr_async_deb", deb_l, 4'h0);
        chk("mr_async_deb_n", deb_n, 4'h0);
        #1;
        rst_n = 1'b1;
        tick(5);
        chk("mr_deb_e5", deb_l, 4'h0);
        chk("mr_press_e5", prs_l, 4'h0);
        tick(1);
        chk("mr_deb_e6", deb_l, 4'h5);
        chk("mr_press_e6", prs_l, 4'h5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
